// File: rtl/patdet_ctrl.sv
// patdet_ctrl: run-time controller for the serial pattern detector.
// Holds a programmable pattern/length/mode, gates a valid-qualified bit
// stream into a shift history, detects matches (overlapping or not) and
// stops after a programmed number of matches.
module patdet_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pat,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_ovl,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              match,
  output logic [CNTW-1:0]   match_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [MAXLEN-1:0] pat;
  logic [LENW-1:0]   len;
  logic              ovl;
  logic [CNTW-1:0]   target;
  logic              cfg_ok;
  logic [MAXLEN-1:0] hist;
  logic [LENW-1:0]   fill;

  // Helper terms derived from current state and inputs
  logic [MAXLEN-1:0] len_mask;
  logic [MAXLEN-1:0] hist_new;
  logic [LENW-1:0]   fill_n;
  logic              hit;
  logic [CNTW-1:0]   cnt_inc;
  logic              cfg_valid;
  logic              start_ok;

  // One mask bit per pattern position: position gi takes part in the
  // compare only when it lies inside the programmed length.
  generate
    for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
      assign len_mask[gi] = (LENW'(gi) < len);
    end
  endgenerate

  // Next-bit shift, fill tracking, hit detection and saturating count
  always_comb begin
    hist_new  = {hist[MAXLEN-2:0], in_bit};
    fill_n    = (fill >= len) ? len : fill + LENW'(1);
    hit       = (fill_n == len) && (((hist_new ^ pat) & len_mask) == '0);
    cnt_inc   = (match_cnt == {CNTW{1'b1}}) ? match_cnt : match_cnt + CNTW'(1);
    cfg_valid = (cfg_len != '0) && (cfg_len <= LENW'(MAXLEN));
    // A configuration accepted this same cycle already qualifies a start.
    start_ok  = cfg_ok || (cfg_we && cfg_valid);
  end

  // Controller FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat       <= '0;
      len       <= '0;
      ovl       <= 1'b0;
      target    <= '0;
      cfg_ok    <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      in_ready  <= 1'b0;
      match     <= 1'b0;
      match_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      match <= 1'b0;
      err   <= 1'b0;
      case (state)
        RUN: begin
          if (abort) begin
            // Abort wins over any bit offered in the same cycle.
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
          end else begin
            if (cfg_we) begin
              err <= 1'b1;
            end
            if (in_valid) begin
              hist <= hist_new;
              fill <= (hit && !ovl) ? '0 : fill_n;
              if (hit) begin
                match     <= 1'b1;
                match_cnt <= cnt_inc;
                if ((target != '0) && (cnt_inc == target)) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  in_ready <= 1'b0;
                  done     <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          // IDLE and DONE: configuration first, then abort, then start.
          if (cfg_we) begin
            if (cfg_valid) begin
              pat    <= cfg_pat;
              len    <= cfg_len;
              ovl    <= cfg_ovl;
              target <= cfg_target;
              cfg_ok <= 1'b1;
              state  <= IDLE;
              done   <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            if (start_ok) begin
              hist      <= '0;
              fill      <= '0;
              match_cnt <= '0;
              state     <= RUN;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              done      <= 1'b0;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
              done  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_patdet_ctrl.sv
// Directed testbench for patdet_ctrl: overlap/non-overlap runs, target
// stop, rejected commands, gapped input, abort and mid-run reset.
module tb_patdet_ctrl;

  localparam int MAXLEN = 8;
  localparam int LENW   = 4;
  localparam int CNTW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [MAXLEN-1:0] cfg_pat;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_ovl;
  logic [CNTW-1:0]   cfg_target;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic              match;
  logic [CNTW-1:0]   match_cnt;
  logic              busy;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  patdet_ctrl #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_ovl    (cfg_ovl),
    .cfg_target (cfg_target),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .match      (match),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [MAXLEN-1:0] p, input logic [LENW-1:0] l,
                     input logic o, input logic [CNTW-1:0] t);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_target = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1; in_bit = b;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] stream;      // bits sent MSB first: 1,1,0,1,1,0,1,1
  logic [7:0] exp_ovl;     // expected match after each bit, MSB = bit 1
  logic [7:0] exp_novl;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    stream   = 8'b1101_1011;
    exp_ovl  = 8'b0000_1001;
    exp_novl = 8'b0000_1000;

    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_match", match, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    $display("step reset: busy=%0b done=%0b cnt=%0d", busy, done, match_cnt);

    // Overlap run
    cfg(8'b0001_1011, 4'd5, 1'b1, 8'd0);
    chk("ovl_cfg_err", err, 0);
    do_start();
    chk("ovl_busy", busy, 1);
    chk("ovl_ready", in_ready, 1);
    for (int i = 7; i >= 0; i--) begin
      send(stream[i]);
      chk("ovl_match", match, exp_ovl[i]);
    end
    chk("ovl_cnt", match_cnt, 2);
    tick();
    chk("ovl_match_low", match, 0);
    $display("step overlap run: cnt=%0d", match_cnt);
    do_abort();
    chk("ovl_abort_busy", busy, 0);
    chk("ovl_abort_cnt", match_cnt, 2);

    // Non-overlap run, then three more bits complete a second match
    cfg(8'b0001_1011, 4'd5, 1'b0, 8'd0);
    do_start();
    chk("novl_cnt_clr", match_cnt, 0);
    for (int i = 7; i >= 0; i--) begin
      send(stream[i]);
      chk("novl_match", match, exp_novl[i]);
    end
    chk("novl_cnt1", match_cnt, 1);
    send(1'b0); chk("novl_b9", match, 0);
    send(1'b1); chk("novl_b10", match, 0);
    send(1'b1); chk("novl_b11", match, 1);
    chk("novl_cnt2", match_cnt, 2);
    $display("step non-overlap run: cnt=%0d", match_cnt);
    do_abort();

    // Target stop after two matches
    cfg(8'b0001_1011, 4'd5, 1'b1, 8'd2);
    do_start();
    for (int i = 7; i >= 1; i--) send(stream[i]);
    chk("tgt_ready_pre", in_ready, 1);
    send(stream[0]);
    chk("tgt_match", match, 1);
    chk("tgt_done", done, 1);
    chk("tgt_busy", busy, 0);
    chk("tgt_ready", in_ready, 0);
    chk("tgt_cnt", match_cnt, 2);
    send(1'b1);
    send(1'b1);
    chk("tgt_extra_match", match, 0);
    chk("tgt_hold_done", done, 1);
    chk("tgt_hold_cnt", match_cnt, 2);
    chk("tgt_hold_ready", in_ready, 0);
    $display("step target stop: done=%0b cnt=%0d", done, match_cnt);
    do_abort();
    chk("tgt_abort_done", done, 0);
    chk("tgt_abort_err", err, 0);

    // Rejected commands
    rst = 1'b1; tick(); rst = 1'b0;
    cfg(8'b0000_0101, 4'd0, 1'b1, 8'd0);
    chk("bad_len0_err", err, 1);
    tick();
    chk("err_pulse_low", err, 0);
    cfg(8'b0000_0101, 4'd9, 1'b1, 8'd0);
    chk("bad_len9_err", err, 1);
    do_start();
    chk("start_nocfg_err", err, 1);
    chk("start_nocfg_busy", busy, 0);
    $display("step bad config: busy=%0b", busy);

    // Good config, cfg_we during RUN rejected, gapped stream
    cfg(8'b0000_0101, 4'd3, 1'b1, 8'd0);
    chk("good_cfg_err", err, 0);
    do_start();
    chk("gap_busy", busy, 1);
    cfg(8'b0000_0111, 4'd3, 1'b1, 8'd0);
    chk("run_cfg_err", err, 1);
    send(1'b1);
    tick(); tick();
    chk("gap_m1", match, 0);
    send(1'b0);
    tick();
    chk("gap_m2", match, 0);
    send(1'b1);
    chk("gap_match", match, 1);
    chk("gap_cnt", match_cnt, 1);
    $display("step gaps: cnt=%0d", match_cnt);

    // Abort together with a bit that would have matched
    send(1'b0);
    chk("abort_pre", match, 0);
    abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_match", match, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", match_cnt, 1);
    $display("step abort: busy=%0b cnt=%0d", busy, match_cnt);

    // Reset mid-run after 4 of 5 bits
    cfg(8'b0001_1011, 4'd5, 1'b1, 8'd0);
    do_start();
    send(1'b1); send(1'b1); send(1'b0); send(1'b1);
    chk("mid_nomatch", match, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_cnt", match_cnt, 0);
    chk("mid_rst_done", done, 0);
    do_start();
    chk("mid_start_err", err, 1);
    chk("mid_start_busy", busy, 0);
    $display("step reset mid-run: err=%0b busy=%0b", err, busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/patdet_ctrl.md
Name: patdet_ctrl

Overview:
- Run-time controller and sequencer for the serial pattern detector datapath.
- Holds a programmable pattern, pattern length and overlap/non-overlap mode.
- Gates a valid-qualified bit stream into the shift/compare logic and counts matches.
- Stops and flags completion after a programmed number of matches; sits between the configuration master and the bit-stream source.

Parameters:
- MAXLEN, 8, maximum pattern length in bits (at least 2)
- LENW, 4, width of the length field; must satisfy 2**LENW > MAXLEN
- CNTW, 8, width of the match counter and target

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe
- cfg_pat  in  MAXLEN  pattern; bit 0 is the most recent bit
- cfg_len  in  LENW  pattern length; valid range 1..MAXLEN
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_target  in  CNTW  match count that ends a run; 0 = run until abort
- start  in  1  begin a run (pulse)
- abort  in  1  terminate a run (pulse)
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial data bit
- in_ready  out  1  controller accepts bits (bit transfers when in_valid & in_ready)
- match  out  1  one-cycle pulse per detected match
- match_cnt  out  CNTW  matches in the current or last run
- busy  out  1  state is RUN
- done  out  1  state is DONE
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset: on rst high at an edge, all outputs go to 0, state goes to IDLE, and pattern, length, mode, target, history, fill and cfg_ok all clear to 0. rst overrides every other input, including mid-run.
- States: IDLE, RUN and DONE. in_ready = busy = (state==RUN). done = (state==DONE). All outputs are registered.
- cfg_we in IDLE or DONE:
  - cfg_len in 1..MAXLEN: latch all cfg_* fields, set cfg_ok, and go to IDLE (DONE -> IDLE).
  - cfg_len 0 or above MAXLEN: pulse err; configuration is unchanged.
- cfg_we in RUN: ignored and err pulses.
- start in IDLE or DONE:
  - cfg_ok = 1: clear history, fill and match_cnt, then go to RUN.
  - cfg_ok = 0: pulse err and stay in IDLE.
- start in RUN: ignored, no err.
- cfg_we and start in the same cycle: cfg_we is processed first. start then uses the new configuration if it was accepted, otherwise the old one.
- RUN, accepted bit (in_valid high, abort low):
  - hist <= {hist[MAXLEN-2:0], in_bit}.
  - fill_n = min(fill+1, len).
  - The bit is a hit when fill_n == len and the low len bits of the new hist equal the low len bits of the pattern.
  - On a hit, match pulses and match_cnt increments on the same edge that shifts the bit in. Latency is 1 cycle from the accepting edge.
  - match_cnt saturates at 2**CNTW-1; match still pulses after saturation.
  - Overlap mode: fill stays at len after a hit.
  - Non-overlap mode: fill clears to 0 after a hit, so the next match needs len fresh bits.
- RUN, no in_valid: no state change. Gaps of any length are allowed.
- Target reached: when cfg_target != 0 and the incremented match_cnt == cfg_target, go to DONE on that same edge. in_ready is 0 from the next cycle; the match pulse is still issued.
- abort in RUN: go to IDLE. abort has priority over a simultaneous bit, which is dropped (no shift, no match). match_cnt holds its value.
- abort in IDLE or DONE: go to IDLE, no err.
- DONE: holds match_cnt and done until start, cfg_we or abort.

Test Plan:
- Overlap run: rst; cfg pat=5'b11011, len=5, ovl=1, target=0; start; stream 1,1,0,1,1,0,1,1 continuously -> match pulses after bits 5 and 8; match_cnt=2.
- Non-overlap run: same stream with ovl=0 -> single match after bit 5; match_cnt=1. Then feed 0,1,1 -> match_cnt=2.
- Target stop: ovl=1, target=2, stream 11011011 plus 2 extra bits -> DONE and in_ready=0 from the cycle after bit 8. The extra bits are not accepted; done=1 and match_cnt=2 hold.
- Bad configuration: cfg_len=0 -> err pulse. Then start with no prior good configuration -> err pulse, busy stays 0. cfg_we during RUN -> err pulse, pattern unchanged.
- Gaps and abort: pattern 3'b101 sent as bits 1,0,1 with idle cycles of in_valid=0 between them -> one match. Then abort asserted together with an in_valid bit -> IDLE, no match, match_cnt unchanged.
- Reset mid-run: rst during RUN after 4 of 5 pattern bits -> all outputs 0 and IDLE next cycle. start without reconfiguring -> err pulse, because cfg_ok was cleared.
